// File: rtl/muller_c_elem_formal_if.sv
`default_nettype none
// ============================================================================
// Module   : muller_c_elem_formal_if
// Brief    : Pad-bus bundle for the Muller C-element bank (inputs, states,
//            transition counter, sticky error flag).
// Revision : 1.0 - initial release
// ============================================================================
interface muller_c_elem_formal_if #(
    parameter int CNT_W = 8
);
    logic [5:0]       io_in;
    logic [2:0]       io_out;
    logic             c_all;
    logic [CNT_W-1:0] toggle_cnt;
    logic             err;

    modport master (
        output io_in,
        input  io_out,
        input  c_all,
        input  toggle_cnt,
        input  err
    );

    modport slave (
        input  io_in,
        output io_out,
        output c_all,
        output toggle_cnt,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/muller_c_elem_formal.sv
`default_nettype none
// ============================================================================
// Module   : muller_c_elem_formal
// Brief    : Three registered 2-input C-elements feeding a 3-input C-element,
//            a saturating transition counter and a sticky invariant monitor.
//            Optional macro FORMAL_ASSERT_EN adds assert/cover/assume code.
// Revision : 1.0 - initial release
// ============================================================================
module muller_c_elem_formal #(
    parameter int CNT_W = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    muller_c_elem_formal_if.slave       bus
);

    logic [2:0]       r_q;
    logic             r_call;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Monitor history: inputs and element states as seen one edge earlier.
    logic [5:0]       r_hist_in;
    logic [2:0]       r_hist_q;
    logic             r_hist_call;
    logic             r_mon_valid;

    logic [2:0]       w_a;
    logic [2:0]       w_b;
    logic [2:0]       w_q_nxt;
    logic             w_call_nxt;
    logic             w_cnt_sat;
    logic [2:0]       w_q_bad;
    logic             w_c_bad;
    logic             w_violation;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < 3; k++) begin
            w_a[k] = bus.io_in[2*k];
            w_b[k] = bus.io_in[2*k+1];
        end
        w_q_nxt    = (w_a & w_b) | (r_q & (w_a | w_b));
        w_call_nxt = (&r_q) | (r_call & (|r_q));
        w_cnt_sat  = &r_cnt;
    end

    // A state may only change to a value that all its previous inputs agreed on.
    always_comb begin
        w_q_bad = '0;
        for (int k = 0; k < 3; k++) begin
            w_q_bad[k] = (r_q[k] ^ r_hist_q[k]) &
                         ((r_hist_in[2*k] != r_q[k]) | (r_hist_in[2*k+1] != r_q[k]));
        end
        w_c_bad     = (r_call ^ r_hist_call) & (r_hist_q != {3{r_call}});
        w_violation = r_mon_valid & ((|w_q_bad) | w_c_bad);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q         <= '0;
            r_call      <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_hist_in   <= '0;
            r_hist_q    <= '0;
            r_hist_call <= 1'b0;
            r_mon_valid <= 1'b0;
        end else begin
            r_q         <= w_q_nxt;
            r_call      <= w_call_nxt;
            if ((w_call_nxt != r_call) && !w_cnt_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_err       <= r_err | w_violation;
            r_hist_in   <= bus.io_in;
            r_hist_q    <= r_q;
            r_hist_call <= r_call;
            r_mon_valid <= 1'b1;
        end
    end

    assign bus.io_out     = r_q;
    assign bus.c_all      = r_call;
    assign bus.toggle_cnt = r_cnt;
    assign bus.err        = r_err;

`ifdef FORMAL_ASSERT_EN
    // Declaration initialiser gives the solver a known first cycle.
    logic r_f_started = 1'b0;

    always_ff @(posedge clk) begin
        r_f_started <= 1'b1;
    end

    always_comb begin
        if (!r_f_started) begin
            assume (!rst_n);
        end
    end

    generate
        for (genvar k = 0; k < 3; k++) begin : g_formal_elem
            a_hold_on_mismatch : assert property (@(posedge clk)
                (r_f_started && rst_n && (bus.io_in[2*k] != bus.io_in[2*k+1]))
                |=> (r_q[k] == $past(r_q[k])));
            c_q_rise : cover property (@(posedge clk) r_f_started && $rose(r_q[k]));
            c_q_fall : cover property (@(posedge clk) r_f_started && $fell(r_q[k]));
        end
    endgenerate

    a_no_err  : assert property (@(posedge clk) r_f_started |-> !r_err);
    c_call_up : cover property (@(posedge clk) r_f_started && $rose(r_call));
    c_cnt_sat : cover property (@(posedge clk) r_f_started && w_cnt_sat);
`endif

endmodule
`default_nettype wire

// File: tb/tb_muller_c_elem_formal.sv
`default_nettype none
// ============================================================================
// Module   : tb_muller_c_elem_formal
// Brief    : Randomised and directed bench against a counting reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muller_c_elem_formal;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    muller_c_elem_formal_if #(.CNT_W(CNT_W)) bus ();

    muller_c_elem_formal #(.CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each element follows majority-of-agreeing inputs,
    // c_all follows unanimity of the previous element states.
    bit [2:0] m_q;
    bit       m_c;
    int       m_cnt;

    task automatic model_step(input bit rstn, input bit [5:0] in);
        bit [2:0] old_q;
        bit       new_c;
        int       ones;
        if (!rstn) begin
            m_q = '0; m_c = 1'b0; m_cnt = 0;
        end else begin
            old_q = m_q;
            ones  = 0;
            for (int k = 0; k < 3; k++) if (old_q[k]) ones++;
            new_c = (ones == 3) ? 1'b1 : (ones == 0) ? 1'b0 : m_c;
            for (int k = 0; k < 3; k++)
                if (in[2*k] == in[2*k+1]) m_q[k] = in[2*k];
            if (new_c != m_c && m_cnt < CNT_MAX) m_cnt++;
            m_c = new_c;
        end
    endtask

    task automatic cyc(input bit rstn, input bit [5:0] in);
        @(negedge clk);
        rst_n      = rstn;
        bus.io_in  = in;
        @(posedge clk);
        model_step(rstn, in);
        #1;
    endtask

    task automatic test_reset;
        cyc(1'b0, 6'h3f);
        cyc(1'b0, 6'h00);
        n_tests++;
        if (bus.io_out !== 3'b000 || bus.c_all !== 1'b0 || bus.toggle_cnt !== 8'd0 || bus.err !== 1'b0) begin
            $display("FAIL reset: out=%b c=%b cnt=%0d err=%b required 000 0 0 0",
                     bus.io_out, bus.c_all, bus.toggle_cnt, bus.err);
            n_fail++;
        end
    endtask

    task automatic test_hold_mismatch;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 6'b010000);
            n_tests++;
            if (bus.io_out !== 3'b000 || bus.c_all !== 1'b0 || bus.toggle_cnt !== 8'd0 || bus.err !== 1'b0) begin
                $display("FAIL hold_mismatch[%0d]: out=%b c=%b cnt=%0d err=%b required 000 0 0 0",
                         i, bus.io_out, bus.c_all, bus.toggle_cnt, bus.err);
                n_fail++;
            end
        end
    endtask

    task automatic test_set_clear;
        cyc(1'b1, 6'b111111);
        n_tests++;
        if (bus.io_out !== 3'b111 || bus.c_all !== 1'b0) begin
            $display("FAIL set_lat1: out=%b c=%b required 111 0", bus.io_out, bus.c_all);
            n_fail++;
        end
        cyc(1'b1, 6'b101010);
        n_tests++;
        if (bus.io_out !== 3'b111 || bus.c_all !== 1'b1 || bus.toggle_cnt !== 8'd1) begin
            $display("FAIL set_lat2: out=%b c=%b cnt=%0d required 111 1 1",
                     bus.io_out, bus.c_all, bus.toggle_cnt);
            n_fail++;
        end
        cyc(1'b1, 6'b101010);
        n_tests++;
        if (bus.io_out !== 3'b111 || bus.c_all !== 1'b1 || bus.toggle_cnt !== 8'd1) begin
            $display("FAIL set_hold: out=%b c=%b cnt=%0d required 111 1 1",
                     bus.io_out, bus.c_all, bus.toggle_cnt);
            n_fail++;
        end
        cyc(1'b1, 6'b000000);
        n_tests++;
        if (bus.io_out !== 3'b000 || bus.c_all !== 1'b1) begin
            $display("FAIL clear_lat1: out=%b c=%b required 000 1", bus.io_out, bus.c_all);
            n_fail++;
        end
        cyc(1'b1, 6'b000000);
        n_tests++;
        if (bus.io_out !== 3'b000 || bus.c_all !== 1'b0 || bus.toggle_cnt !== 8'd2 || bus.err !== 1'b0) begin
            $display("FAIL clear_lat2: out=%b c=%b cnt=%0d err=%b required 000 0 2 0",
                     bus.io_out, bus.c_all, bus.toggle_cnt, bus.err);
            n_fail++;
        end
    endtask

    task automatic test_partial;
        cyc(1'b1, 6'b000011);
        n_tests++;
        if (bus.io_out !== 3'b001 || bus.c_all !== 1'b0) begin
            $display("FAIL partial_one: out=%b c=%b required 001 0", bus.io_out, bus.c_all);
            n_fail++;
        end
        cyc(1'b1, 6'b001111);
        cyc(1'b1, 6'b001111);
        n_tests++;
        if (bus.io_out !== 3'b011 || bus.c_all !== 1'b0 || bus.toggle_cnt !== 8'd2) begin
            $display("FAIL partial_two: out=%b c=%b cnt=%0d required 011 0 2",
                     bus.io_out, bus.c_all, bus.toggle_cnt);
            n_fail++;
        end
    endtask

    task automatic test_saturate;
        cyc(1'b0, 6'h00);
        for (int i = 0; i < 320; i++) begin
            cyc(1'b1, (i % 2 == 0) ? 6'h3f : 6'h00);
            n_tests++;
            if (bus.toggle_cnt !== m_cnt[CNT_W-1:0] || bus.c_all !== m_c) begin
                $display("FAIL saturate_step[%0d]: cnt=%0d c=%b required %0d %b",
                         i, bus.toggle_cnt, bus.c_all, m_cnt, m_c);
                n_fail++;
            end
        end
        n_tests++;
        if (bus.toggle_cnt !== 8'd255) begin
            $display("FAIL saturate_final: cnt=%0d required 255", bus.toggle_cnt);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid;
        int guard;
        cyc(1'b0, 6'h00);
        guard = 0;
        while (!(m_cnt == 5 && m_c) && guard < 50) begin
            cyc(1'b1, (guard % 2 == 0) ? 6'h3f : 6'h00);
            guard++;
        end
        n_tests++;
        if (guard >= 50 || bus.c_all !== 1'b1 || bus.toggle_cnt !== 8'd5 || bus.err !== 1'b0) begin
            $display("FAIL reset_mid_setup: c=%b cnt=%0d err=%b cycles=%0d required 1 5 0",
                     bus.c_all, bus.toggle_cnt, bus.err, guard);
            n_fail++;
        end
        cyc(1'b0, 6'h3f);
        n_tests++;
        if (bus.io_out !== 3'b000 || bus.c_all !== 1'b0 || bus.toggle_cnt !== 8'd0 || bus.err !== 1'b0) begin
            $display("FAIL reset_mid: out=%b c=%b cnt=%0d err=%b required 000 0 0 0",
                     bus.io_out, bus.c_all, bus.toggle_cnt, bus.err);
            n_fail++;
        end
    endtask

    task automatic test_random;
        bit       rstn;
        bit [5:0] in;
        cyc(1'b0, 6'h00);
        for (int i = 0; i < 400; i++) begin
            rstn = ($urandom_range(0, 31) != 0);
            // Bias towards agreeing pairs so elements actually move.
            in = 6'($urandom);
            if ($urandom_range(0, 1) == 1) in = {in[5], in[5], in[3], in[3], in[1], in[1]};
            cyc(rstn, in);
            n_tests++;
            if (bus.io_out !== m_q || bus.c_all !== m_c ||
                bus.toggle_cnt !== m_cnt[CNT_W-1:0] || bus.err !== 1'b0) begin
                $display("FAIL random[%0d]: out=%b c=%b cnt=%0d err=%b required %b %b %0d 0",
                         i, bus.io_out, bus.c_all, bus.toggle_cnt, bus.err, m_q, m_c, m_cnt);
                n_fail++;
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.io_in = '0;
        m_q = '0; m_c = 1'b0; m_cnt = 0;
        test_reset();
        test_hold_mismatch();
        test_set_clear();
        test_partial();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
